// File: rtl/alu_pkg.sv
// Shared definitions for the ALU block family: ctrl codes, datapath sizes and
// the issuer sequencing states.
package alu_pkg;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NREG = 8;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_EQ  = 4'b1100;
  localparam logic [3:0] OP_NOP = 4'b1101;
  localparam logic [3:0] OP_LI  = 4'b1111;

  localparam logic [3:0] NOP_CTRL = OP_NOP;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Ops whose ALU result lands in the register file.
  function automatic logic op_writes_alu(input logic [3:0] op);
    return (op <= OP_EQ);
  endfunction

  function automatic logic op_sets_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/regfile_8x8.sv
// 8 x 8-bit register file: one synchronous write port, three combinational
// read ports (two operands plus debug), synchronous active-low clear.
module regfile_8x8
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rs_data  = mem_q[rs_addr];
  assign rt_data  = mem_q[rt_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_op_issuer.sv
// Sequential initiator for a combinational 8-bit ALU: accepts one instruction
// per three cycles, drives operands, captures the result and writes it back.
//
// state   | meaning
// IDLE    | in_ready high, waiting for in_valid; operands read at accept
// EXEC    | ALU operands/ctrl stable, ALU settling; result captured at edge
// WB      | register/carry writeback at edge, completion pulse follows
module alu_op_issuer
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [DW-1:0] in_imm,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_carry,
  output logic [AW-1:0] out_rd,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] res_q, res_d;
  logic          rc_q, rc_d;
  logic          carry_q, carry_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] y_q, y_d;
  logic          ready_q, ready_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic [AW-1:0] ord_q, ord_d;

  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rs_data, rt_data;

  regfile_8x8 u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (rf_wdata),
    .rs_addr  (in_rs),
    .rt_addr  (in_rt),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      rc_q    <= 1'b0;
      carry_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b1;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      rc_q    <= rc_d;
      carry_q <= carry_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ready_q <= ready_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ord_q   <= ord_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    res_d    = res_q;
    rc_d     = rc_q;
    carry_d  = carry_q;
    ctrl_d   = ctrl_q;
    x_d      = x_q;
    y_d      = y_q;
    ready_d  = ready_q;
    ov_d     = 1'b0;
    od_d     = od_q;
    ord_d    = ord_q;
    rf_we    = 1'b0;
    rf_wdata = res_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          imm_d   = in_imm;
          // Load-immediate never uses the ALU, so keep it parked on NOP.
          ctrl_d  = (in_op == OP_LI) ? NOP_CTRL : in_op;
          x_d     = rs_data;
          y_d     = rt_data;
          ready_d = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_out;
        rc_d    = alu_carry;
        state_d = ST_WB;
      end
      ST_WB: begin
        rf_we    = op_writes_alu(op_q) || (op_q == OP_LI);
        rf_wdata = (op_q == OP_LI) ? imm_q : res_q;
        od_d     = rf_we ? rf_wdata : '0;
        ord_d    = rd_q;
        ov_d     = 1'b1;
        if (op_sets_carry(op_q)) carry_d = rc_q;
        ctrl_d   = NOP_CTRL;
        x_d      = '0;
        y_d      = '0;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign in_ready  = ready_q;
  assign alu_ctrl  = ctrl_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_carry = carry_q;
  assign out_rd    = ord_q;

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Sequential initiator for the 8-bit ALU in the ALU block family (ctrl[3:0], x[7:0], y[7:0] -> out[7:0], carry).
- Owns an 8-entry x 8-bit register file and accepts instructions over a valid/ready handshake.
- Drives ALU operands from registers, captures the ALU result, writes it back, and reports completion.
- Sits between an instruction source and a purely combinational ALU instance.

Parameters:
- DW, 8, datapath width; must match ALU x/y/out.
- NREG, 8, register count; address width AW = 3.
- NOP_CTRL, 4'b1101, ctrl value driven to the ALU when idle.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  issuer can accept an instruction.
- in_op  in  4  ALU ctrl code; 4'b1111 = load immediate.
- in_rd  in  3  destination register.
- in_rs  in  3  source register driven to ALU x.
- in_rt  in  3  source register driven to ALU y.
- in_imm  in  8  immediate, used only by op 4'b1111.
- alu_ctrl  out  4  to ALU ctrl.
- alu_x  out  8  to ALU x.
- alu_y  out  8  to ALU y.
- alu_out  in  8  from ALU out.
- alu_carry  in  1  from ALU carry.
- out_valid  out  1  one-cycle completion pulse.
- out_data  out  8  result written (0 for nop).
- out_carry  out  1  sticky carry flag after this instruction.
- out_rd  out  3  destination of the completed instruction.
- dbg_addr  in  3  register-file debug read address.
- dbg_data  out  8  combinational read of reg[dbg_addr].

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All registers and the carry flag clear to 0; FSM goes to IDLE.
  - in_ready=1, out_valid=0, out_data=0, out_carry=0, out_rd=0.
  - alu_ctrl=NOP_CTRL, alu_x=0, alu_y=0.
- FSM states: IDLE, EXEC, WB. All control and ALU-facing outputs are registered.
- IDLE: in_ready=1.
  - in_valid=1 at an edge: latch op and rd; load alu_ctrl=in_op, alu_x=reg[in_rs], alu_y=reg[in_rt]; go to EXEC.
  - Op 4'b1111: load alu_ctrl=NOP_CTRL and latch in_imm.
- EXEC: in_ready=0; ALU settles combinationally. At the edge, capture alu_out and alu_carry; go to WB.
- WB: in_ready=0.
  - At the edge: perform the writeback, pulse out_valid for the following cycle, return alu_ctrl to NOP_CTRL and x/y to 0, go to IDLE.
  - Latency: accept at edge N, out_valid high during cycle N+2. Throughput: one instruction per 3 cycles.
- Writeback rules:
  - Ops 0000–1100: reg[rd] <= captured alu_out.
  - Op 1111: reg[rd] <= imm.
  - Ops 1101 and 1110: no register write; out_data=0.
- Carry flag:
  - Updated with captured alu_carry only for ops 0000 (add) and 0001 (sub).
  - Unchanged for every other op; out_carry always shows the flag value.
- Hazards: rd == rs or rd == rt is legal. Operands are read at accept, so old values are used. No bypass is needed because the next accept occurs after writeback.
- in_valid is ignored outside IDLE; the source must hold it until in_ready=1.
- out_valid asserts only in the cycle after WB and is never back-to-back.
- Reset mid-operation (EXEC or WB): the instruction is discarded with no writeback and no out_valid. Registers clear.
- dbg_data reflects the write from WB starting in the cycle after the write edge.

Decomposition:
- Shared package alu_pkg:
  - ctrl constants: OP_ADD=0000, OP_SUB=0001, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_EQ=1100, OP_NOP=1101, OP_LI=1111.
  - DW, AW.
  - FSM state enum.
- Sub-module regfile_8x8: one synchronous write port, three combinational read ports (rs, rt, dbg), synchronous active-low clear.

Test Plan:
- Reset, then drive dbg_addr 0..7 -> all dbg_data=0x00; in_ready=1; alu_ctrl=1101.
- LI r1=0x7D, LI r2=0x07, then ADD rd=3, rs=1, rt=2 with the real ALU -> alu_x=0x7D, alu_y=0x07 in EXEC; out_valid 2 cycles after accept; out_data=0x84, out_carry=0; reg3=0x84.
- LI r4=0x33, LI r5=0x14, SUB rd=6, rs=4, rt=5 -> out_data=0x1F; out_carry equals the ALU carry. Then AND rd=7, rs=4, rt=5 -> out_data=0x10 and out_carry unchanged.
- EQ rd=1, rs=2, rt=2 -> reg1=0x01. Then NOP (1101) rd=2 -> out_valid=1, out_data=0, reg2 still 0x07.
- Hold in_valid=1 continuously with 3 queued instructions -> accepted exactly once each, every 3 cycles; in_ready low in EXEC and WB.
- Assert rst_n=0 during EXEC of ADD rd=3 -> no out_valid, reg3=0, carry=0, FSM in IDLE the cycle after release.
